// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD controller.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, CONV, DONE} bcd_state_e;

  localparam int DIGIT_W = 4;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD = 4'd3;

  // Used at elaboration to confirm DIGITS can represent the full input range.
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= ADJ_THRESH) dout = din + ADJ_ADD;
  end

endmodule

// File: rtl/bcd_seq_ctrl.sv
// Iterative shift-and-add-3 binary-to-BCD converter with valid/ready handshakes.
// Optional macro BCD_LZ_SKIP_EN skips the leading zeros of the input at accept.
module bcd_seq_ctrl
  import bcd_pkg::*;
#(
  parameter int IN_W   = 9,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_W-1:0]           in_bin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                      busy
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int TOT_W = BCD_W + IN_W;
  localparam int CNT_W = $clog2(IN_W + 1);

  if (pow10(DIGITS) <= ((64'd1 << IN_W) - 64'd1)) begin : g_param_chk
    $error("bcd_seq_ctrl: DIGITS too small for IN_W");
  end

  bcd_state_e state_q, state_d;
  logic [TOT_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] out_bcd_q, out_bcd_d;

  logic [BCD_W-1:0] adj;
  logic [TOT_W-1:0] shifted;
  logic [TOT_W-1:0] load_val;
  logic [CNT_W-1:0] load_cnt;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (shift_q[IN_W + gi*DIGIT_W +: DIGIT_W]),
      .dout (adj[gi*DIGIT_W +: DIGIT_W])
    );
  end

  // No carry between digits: corrected digits are re-joined with the binary field, then shifted.
  assign shifted = {adj, shift_q[IN_W-1:0]} << 1;

`ifdef BCD_LZ_SKIP_EN
  logic [CNT_W-1:0] lz;
  logic [IN_W-1:0]  bin_sh;

  always_comb begin
    lz = CNT_W'(IN_W);
    for (int i = 0; i < IN_W; i++) begin
      if (in_bin[i]) lz = CNT_W'(IN_W - 1 - i);
    end
  end

  assign bin_sh   = in_bin << lz;
  assign load_val = {{BCD_W{1'b0}}, bin_sh};
  // An all-zero input still takes one CONV cycle so the handshake timing stays uniform.
  assign load_cnt = (lz == CNT_W'(IN_W)) ? CNT_W'(1) : (CNT_W'(IN_W) - lz);
`else
  assign load_val = {{BCD_W{1'b0}}, in_bin};
  assign load_cnt = CNT_W'(IN_W);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      out_bcd_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      out_bcd_q <= out_bcd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    out_bcd_d = out_bcd_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CONV;
          shift_d = load_val;
          cnt_d   = load_cnt;
        end
      end
      CONV: begin
        shift_d = shifted;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d   = DONE;
          out_bcd_d = shifted[TOT_W-1 -: BCD_W];
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_bcd   = out_bcd_q;
  end

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Randomized self-checking bench for bcd_seq_ctrl against a cycle-accurate behavioural model.
module tb_bcd_seq_ctrl;

  localparam int IN_W   = 9;
  localparam int DIGITS = 3;
  localparam int BCD_W  = 4 * DIGITS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_bin = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [BCD_W-1:0] out_bcd;
  logic             busy;

  int errors = 0;
  int checks = 0;
  int fail_prints = 0;

  always #5 clk = ~clk;

  bcd_seq_ctrl #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .busy      (busy)
  );

  function automatic logic [BCD_W-1:0] to_bcd(input int v);
    logic [BCD_W-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int d = 0; d < DIGITS; d++) begin
      r[d*4 +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Number of conversion cycles for a given input value.
  function automatic int lat_of(input int v);
`ifdef BCD_LZ_SKIP_EN
    int b;
    b = 0;
    while ((v >> b) != 0) b++;
    return (b == 0) ? 1 : b;
`else
    return IN_W + (v - v);
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // Behavioural reference: a pending job counts down its latency, then holds its result.
  bit               m_en = 0;
  bit               m_pending = 0;
  bit               m_valid = 0;
  int               m_left = 0;
  int               m_val = 0;
  logic [BCD_W-1:0] m_bcd = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pending = 0;
      m_valid   = 0;
      m_left    = 0;
      m_bcd     = '0;
      m_en      = 1;
    end else if (m_valid) begin
      if (out_ready) m_valid = 0;
    end else if (m_pending) begin
      m_left--;
      if (m_left == 0) begin
        m_pending = 0;
        m_valid   = 1;
        m_bcd     = to_bcd(m_val);
      end
    end else if (in_valid) begin
      m_pending = 1;
      m_val     = int'(in_bin);
      m_left    = lat_of(int'(in_bin));
    end
  end

  always @(negedge clk) begin
    if (m_en) begin
      chk("in_ready",  int'(in_ready),  int'(!m_pending && !m_valid));
      chk("busy",      int'(busy),      int'(m_pending || m_valid));
      chk("out_valid", int'(out_valid), int'(m_valid));
      chk("out_bcd",   int'(out_bcd),   int'(m_bcd));
    end
  end

  // Counts negedges (from the accept drive point) until out_valid is seen.
  task automatic wait_valid(input string name, output int cyc);
    cyc = 0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) in_valid = 1'b0;
      if (out_valid) break;
    end
    if (!out_valid) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (!in_ready) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int tot;
    logic [BCD_W-1:0] held;

    // Pin the model itself against hand-computed values.
    chk("model_511", int'(to_bcd(511)), 'h511);
    chk("model_255", int'(to_bcd(255)), 'h255);
    chk("model_lat511", lat_of(511), 9);
`ifdef BCD_LZ_SKIP_EN
    chk("model_lat9", lat_of(9), 4);
    chk("model_lat0", lat_of(0), 1);
`else
    chk("model_lat9", lat_of(9), 9);
`endif

    repeat (2) @(negedge clk);
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_bcd",   int'(out_bcd),   0);
    chk("rst_busy",      int'(busy),      0);
    rst_n = 1'b1;
    @(negedge clk);

    // 511 with out_ready held high.
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_bin = 9'd511;
    wait_valid("t511", cyc);
    chk("t511_latency", cyc, 10);
    chk("t511_bcd", int'(out_bcd), 'h511);
    @(negedge clk);
    chk("t511_back_idle", int'(in_ready), 1);

    // Back-to-back 0, 9, 100 with in_valid held high.
    in_valid = 1'b1;
    in_bin = 9'd0;
    wait_valid("t0", cyc);
    chk("t0_latency", cyc, lat_of(0) + 1);
    chk("t0_bcd", int'(out_bcd), 'h000);
    in_valid = 1'b1;
    in_bin = 9'd9;
    @(negedge clk);
    wait_valid("t9", cyc);
    chk("t9_latency", cyc, lat_of(9) + 1);
    chk("t9_bcd", int'(out_bcd), 'h009);
    in_valid = 1'b1;
    in_bin = 9'd100;
    @(negedge clk);
    wait_valid("t100", cyc);
    chk("t100_latency", cyc, lat_of(100) + 1);
    chk("t100_bcd", int'(out_bcd), 'h100);
    @(negedge clk);

    // 255 with a 5-cycle output stall.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_bin = 9'd255;
    wait_valid("t255", cyc);
    held = out_bcd;
    repeat (5) begin
      @(negedge clk);
      chk("t255_hold_valid", int'(out_valid), 1);
      chk("t255_hold_bcd", int'(out_bcd), int'(held));
    end
    chk("t255_bcd", int'(out_bcd), 'h255);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t255_release", int'(in_ready), 1);

    // 300 with an in_valid glitch and in_bin change mid-conversion.
    in_valid = 1'b1;
    in_bin = 9'd300;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    in_bin = 9'd7;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("t300_bcd", int'(out_bcd), 'h300);
    @(negedge clk);
    chk("t300_no_relaunch", int'(busy), 0);

    // 487 interrupted by reset during conversion, then redone.
    in_valid = 1'b1;
    in_bin = 9'd487;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t487_rst_ready", int'(in_ready), 1);
    chk("t487_rst_valid", int'(out_valid), 0);
    chk("t487_rst_bcd", int'(out_bcd), 0);
    in_valid = 1'b1;
    in_bin = 9'd487;
    wait_valid("t487", cyc);
    chk("t487_bcd", int'(out_bcd), 'h487);
    @(negedge clk);

    // Exhaustive sweep with random output stalls; the per-cycle model check covers results.
    tot = 0;
    for (int v = 0; v < (1 << IN_W); v++) begin
      wait_idle();
      in_valid = 1'b1;
      in_bin = IN_W'(v);
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      in_valid = 1'b0;
      in_bin = IN_W'($urandom);
      tot++;
    end
    out_ready = 1'b1;
    repeat (IN_W + 4) @(negedge clk);
    chk("sweep_count", tot, 1 << IN_W);
    chk("sweep_end_idle", int'(in_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
